bnn_frame_sched: RTL and testbench

- Sequencer in front of the BNN accelerator top.
- Gates three upstream streams into the accelerator in a fixed order: conv weights, FC weights, then 784 image pixels per image.
- Drives start_cnn and waits for cnn_done.
- Collects NUM_CLASSES result beats per image and emits the argmax class. Repeats for a programmed number of images.

---
 rtl/bnn_frame_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_bnn_frame_sched.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_frame_sched.sv
// bnn_frame_sched: batch sequencer in front of the BNN accelerator.
// Gates weight/image streams by phase, runs the core, emits per-image argmax.
module bnn_frame_sched #(
    parameter int DW          = 32,
    parameter int IMG_BEATS   = 784,
    parameter int CW_BEATS    = 150,
    parameter int FCW_BEATS   = 1960,
    parameter int NUM_CLASSES = 10,
    parameter int TIMEOUT     = 65535
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cfg_start,
    input  logic [15:0]          cfg_num_images,
    input  logic                 cfg_load_w,
    input  logic                 s_img_tvalid,
    input  logic [DW-1:0]        s_img_tdata,
    output logic                 s_img_tready,
    input  logic                 s_w_tvalid,
    input  logic                 s_w_tdata,
    output logic                 s_w_tready,
    input  logic                 s_wfc_tvalid,
    input  logic                 s_wfc_tdata,
    output logic                 s_wfc_tready,
    output logic                 m_img_tvalid,
    output logic [DW-1:0]        m_img_tdata,
    input  logic                 m_img_tready,
    output logic                 m_w_tvalid,
    output logic                 m_w_tdata,
    input  logic                 m_w_tready,
    output logic                 m_wfc_tvalid,
    output logic                 m_wfc_tdata,
    input  logic                 m_wfc_tready,
    output logic                 start_cnn,
    input  logic                 cnn_done,
    input  logic                 result_tvalid,
    input  logic signed [DW-1:0] result_tdata,
    output logic                 class_tvalid,
    output logic [3:0]           class_idx,
    output logic signed [DW-1:0] class_score,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int MAXB = (CW_BEATS > FCW_BEATS)
                        ? ((CW_BEATS > IMG_BEATS) ? CW_BEATS : IMG_BEATS)
                        : ((FCW_BEATS > IMG_BEATS) ? FCW_BEATS : IMG_BEATS);
    localparam int BW = $clog2(MAXB + 1);
    localparam int RW = $clog2(NUM_CLASSES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_CW,
        S_LOAD_FCW,
        S_LOAD_IMG,
        S_RUN,
        S_EMIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                 state;
    logic [BW-1:0]          beat_cnt;
    logic [RW-1:0]          res_cnt;
    logic [TW-1:0]          run_cnt;
    logic [15:0]            img_cnt;
    logic [15:0]            num_images;
    logic                   done_seen;
    logic signed [DW-1:0]   max_score;
    logic [3:0]             max_idx;

    logic                   en_w;
    logic                   en_wfc;
    logic                   en_img;
    logic                   w_fire;
    logic                   wfc_fire;
    logic                   img_fire;
    logic                   res_fire;
    logic                   take_max;
    logic                   res_full;
    logic                   run_exit;
    logic signed [DW-1:0]   nxt_score;
    logic [3:0]             nxt_idx;

    assign en_w   = (state == S_LOAD_CW);
    assign en_wfc = (state == S_LOAD_FCW);
    assign en_img = (state == S_LOAD_IMG);

    assign m_w_tvalid   = s_w_tvalid & en_w;
    assign s_w_tready   = m_w_tready & en_w;
    assign m_w_tdata    = s_w_tdata;
    assign m_wfc_tvalid = s_wfc_tvalid & en_wfc;
    assign s_wfc_tready = m_wfc_tready & en_wfc;
    assign m_wfc_tdata  = s_wfc_tdata;
    assign m_img_tvalid = s_img_tvalid & en_img;
    assign s_img_tready = m_img_tready & en_img;
    assign m_img_tdata  = s_img_tdata;

    assign w_fire   = m_w_tvalid & m_w_tready;
    assign wfc_fire = m_wfc_tvalid & m_wfc_tready;
    assign img_fire = m_img_tvalid & m_img_tready;

    // beats past NUM_CLASSES are dropped; first beat always seeds the max
    assign res_fire  = (state == S_RUN) && result_tvalid
                    && (res_cnt < RW'(NUM_CLASSES));
    assign take_max  = res_fire
                    && ((res_cnt == '0) || (result_tdata > max_score));
    assign nxt_score = take_max ? result_tdata : max_score;
    assign nxt_idx   = take_max ? 4'(res_cnt) : max_idx;
    assign res_full  = (res_cnt == RW'(NUM_CLASSES))
                    || (res_fire && (res_cnt == RW'(NUM_CLASSES - 1)));
    assign run_exit  = (done_seen || cnn_done) && res_full;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            beat_cnt     <= '0;
            res_cnt      <= '0;
            run_cnt      <= '0;
            img_cnt      <= '0;
            num_images   <= '0;
            done_seen    <= 1'b0;
            max_score    <= '0;
            max_idx      <= '0;
            start_cnn    <= 1'b0;
            class_tvalid <= 1'b0;
            class_idx    <= '0;
            class_score  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done         <= 1'b0;
            class_tvalid <= 1'b0;
            unique case (state)
                S_IDLE, S_ERR: begin
                    if (cfg_start) begin
                        err        <= 1'b0;
                        num_images <= cfg_num_images;
                        img_cnt    <= '0;
                        if (cfg_num_images == 16'd0) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            busy  <= 1'b1;
                            state <= cfg_load_w ? S_LOAD_CW : S_LOAD_IMG;
                        end
                    end
                end
                S_LOAD_CW: begin
                    if (w_fire) begin
                        if (beat_cnt == BW'(CW_BEATS - 1)) begin
                            beat_cnt <= '0;
                            state    <= S_LOAD_FCW;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                S_LOAD_FCW: begin
                    if (wfc_fire) begin
                        if (beat_cnt == BW'(FCW_BEATS - 1)) begin
                            beat_cnt <= '0;
                            state    <= S_LOAD_IMG;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                S_LOAD_IMG: begin
                    if (img_fire) begin
                        if (beat_cnt == BW'(IMG_BEATS - 1)) begin
                            beat_cnt  <= '0;
                            res_cnt   <= '0;
                            run_cnt   <= '0;
                            done_seen <= 1'b0;
                            start_cnn <= 1'b1;
                            state     <= S_RUN;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (res_fire) begin
                        res_cnt <= res_cnt + RW'(1);
                    end
                    max_score <= nxt_score;
                    max_idx   <= nxt_idx;
                    if (cnn_done) begin
                        done_seen <= 1'b1;
                    end
                    // a completion in the final allowed cycle still wins
                    if (run_exit) begin
                        start_cnn    <= 1'b0;
                        class_tvalid <= 1'b1;
                        class_idx    <= nxt_idx;
                        class_score  <= nxt_score;
                        img_cnt      <= img_cnt + 16'd1;
                        state        <= S_EMIT;
                    end else if (run_cnt == TW'(TIMEOUT - 1)) begin
                        start_cnn <= 1'b0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_ERR;
                    end else begin
                        run_cnt <= run_cnt + TW'(1);
                    end
                end
                S_EMIT: begin
                    if (img_cnt == num_images) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        state <= S_LOAD_IMG;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_frame_sched.sv
// tb_bnn_frame_sched: random streams, accelerator responder model and
// scoreboard of per-image argmax results for bnn_frame_sched.
module tb_bnn_frame_sched;

    localparam int DW  = 32;
    localparam int IMG = 784;
    localparam int CW  = 150;
    localparam int FCW = 1960;
    localparam int NC  = 10;
    localparam int TO  = 100;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b1;
    logic                 cfg_start;
    logic [15:0]          cfg_num_images;
    logic                 cfg_load_w;
    logic                 s_img_tvalid, s_img_tready;
    logic [DW-1:0]        s_img_tdata;
    logic                 s_w_tvalid, s_w_tdata, s_w_tready;
    logic                 s_wfc_tvalid, s_wfc_tdata, s_wfc_tready;
    logic                 m_img_tvalid, m_img_tready;
    logic [DW-1:0]        m_img_tdata;
    logic                 m_w_tvalid, m_w_tdata, m_w_tready;
    logic                 m_wfc_tvalid, m_wfc_tdata, m_wfc_tready;
    logic                 start_cnn, cnn_done, result_tvalid;
    logic signed [DW-1:0] result_tdata;
    logic                 class_tvalid;
    logic [3:0]           class_idx;
    logic signed [DW-1:0] class_score;
    logic                 busy, done, err;

    bnn_frame_sched #(
        .DW(DW), .IMG_BEATS(IMG), .CW_BEATS(CW), .FCW_BEATS(FCW),
        .NUM_CLASSES(NC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cfg_start(cfg_start), .cfg_num_images(cfg_num_images),
        .cfg_load_w(cfg_load_w),
        .s_img_tvalid(s_img_tvalid), .s_img_tdata(s_img_tdata),
        .s_img_tready(s_img_tready),
        .s_w_tvalid(s_w_tvalid), .s_w_tdata(s_w_tdata),
        .s_w_tready(s_w_tready),
        .s_wfc_tvalid(s_wfc_tvalid), .s_wfc_tdata(s_wfc_tdata),
        .s_wfc_tready(s_wfc_tready),
        .m_img_tvalid(m_img_tvalid), .m_img_tdata(m_img_tdata),
        .m_img_tready(m_img_tready),
        .m_w_tvalid(m_w_tvalid), .m_w_tdata(m_w_tdata),
        .m_w_tready(m_w_tready),
        .m_wfc_tvalid(m_wfc_tvalid), .m_wfc_tdata(m_wfc_tdata),
        .m_wfc_tready(m_wfc_tready),
        .start_cnn(start_cnn), .cnn_done(cnn_done),
        .result_tvalid(result_tvalid), .result_tdata(result_tdata),
        .class_tvalid(class_tvalid), .class_idx(class_idx),
        .class_score(class_score),
        .busy(busy), .done(done), .err(err)
    );

    initial forever #5 clk = ~clk;

    typedef logic [NC-1:0][DW-1:0] scores_t;
    typedef struct {
        scores_t s;
        int      mode;
        int      exp_img;
    } job_t;
    typedef struct {
        int                   idx;
        logic signed [DW-1:0] score;
        int                   w;
        int                   wfc;
        int                   img;
    } exp_t;

    job_t jobs[$];
    exp_t scb[$];
    int checks = 0;
    int errors = 0;
    int w_beats = 0, wfc_beats = 0, img_beats = 0;
    int mw = 0, mwfc = 0, mimg = 0;
    int class_seen = 0, class_exp = 0;
    int vpct = 100, rpct = 100;

    task automatic check(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ref_argmax(scores_t s);
        int best = 0;
        for (int i = 1; i < NC; i++)
            if ($signed(s[i]) > $signed(s[best])) best = i;
        return best;
    endfunction

    // queue one image: mode 0 done early, 1 same cycle, 2 late, 3 never
    task automatic add_image(scores_t s, int mode, bit first_lw);
        job_t j;
        exp_t e;
        int b;
        if (first_lw) begin
            mw   += CW;
            mwfc += FCW;
        end
        mimg += IMG;
        j.s = s; j.mode = mode; j.exp_img = mimg;
        jobs.push_back(j);
        if (mode != 3) begin
            b = ref_argmax(s);
            e.idx = b; e.score = s[b];
            e.w = mw; e.wfc = mwfc; e.img = mimg;
            scb.push_back(e);
            class_exp++;
        end
    endtask

    task automatic start_batch(int n, bit lw);
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_num_images = 16'(n);
        cfg_load_w = lw;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(int budget, string nm);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_done_seen"}, done, 1);
        @(negedge clk);
        check({nm, "_done_pulse"}, done, 0);
    endtask

    task automatic end_checks(string nm);
        check({nm, "_classes"}, class_seen, class_exp);
        check({nm, "_scb_left"}, scb.size(), 0);
        check({nm, "_jobs_left"}, jobs.size(), 0);
        check({nm, "_w_beats"}, w_beats, mw);
        check({nm, "_wfc_beats"}, wfc_beats, mwfc);
        check({nm, "_img_beats"}, img_beats, mimg);
        check({nm, "_busy_after"}, busy, 0);
    endtask

    task automatic check_outputs_zero(string nm);
        check({nm, "_ctrl"},
              {m_img_tvalid, s_img_tready, m_w_tvalid, s_w_tready,
               m_wfc_tvalid, s_wfc_tready, start_cnn, class_tvalid,
               busy, done, err}, 0);
        check({nm, "_idx"}, class_idx, 0);
        check({nm, "_score"}, class_score, 0);
    endtask

    task automatic run_job(job_t j);
        int b = 0, ex = 0, n = 0;
        bit ds = 0, tv, cd, fin = 0;
        check("start_after_img", img_beats, j.exp_img);
        while (!fin && n < 60) begin
            tv = 0; cd = 0;
            if (b < NC && $urandom_range(99) < 70) begin
                tv = 1;
                result_tdata = j.s[b];
                b++;
                cd = !ds && ((j.mode == 0 && b == 5) || (j.mode == 1 && b == NC));
            end else if (b == NC && j.mode == 2 && ex < 2) begin
                tv = 1;
                result_tdata = 32'sh7fffffff;
                ex++;
            end else if (b == NC && j.mode == 2 && !ds) begin
                cd = 1;
            end
            result_tvalid = tv;
            cnn_done = cd;
            if (cd) ds = 1;
            check("start_held", start_cnn, 1);
            fin = (b == NC) && (ds || j.mode == 3);
            @(negedge clk);
            n++;
        end
        result_tvalid = 1'b0;
        cnn_done = 1'b0;
        if (!fin) check("acc_budget", 0, 1);
        if (j.mode != 3) begin
            check("start_drop", start_cnn, 0);
        end else begin
            n = 0;
            while (start_cnn === 1'b1 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    // stream sources and sinks, with per-stream sequence checking
    initial begin : bus
        bit img_sf, w_sf, wfc_sf;
        int img_src, img_snk, w_src, w_snk, wfc_src, wfc_snk;
        img_sf = 0; w_sf = 0; wfc_sf = 0;
        img_src = 0; img_snk = 0; w_src = 0; w_snk = 0;
        wfc_src = 0; wfc_snk = 0;
        s_img_tvalid = 0; s_img_tdata = 0;
        s_w_tvalid = 0; s_w_tdata = 0;
        s_wfc_tvalid = 0; s_wfc_tdata = 0;
        m_img_tready = 0; m_w_tready = 0; m_wfc_tready = 0;
        forever begin
            @(negedge clk);
            if (!s_img_tvalid || img_sf) begin
                s_img_tvalid = ($urandom_range(99) < vpct);
                s_img_tdata = img_src;
            end
            if (!s_w_tvalid || w_sf) begin
                s_w_tvalid = ($urandom_range(99) < vpct);
                s_w_tdata = w_src[0];
            end
            if (!s_wfc_tvalid || wfc_sf) begin
                s_wfc_tvalid = ($urandom_range(99) < vpct);
                s_wfc_tdata = wfc_src[0];
            end
            m_img_tready = ($urandom_range(99) < rpct);
            m_w_tready = ($urandom_range(99) < rpct);
            m_wfc_tready = ($urandom_range(99) < rpct);
            #1;
            img_sf = s_img_tvalid && s_img_tready;
            w_sf = s_w_tvalid && s_w_tready;
            wfc_sf = s_wfc_tvalid && s_wfc_tready;
            if (img_sf) img_src++;
            if (w_sf) w_src++;
            if (wfc_sf) wfc_src++;
            if (m_img_tvalid && m_img_tready) begin
                check("img_data", m_img_tdata, img_snk);
                check("img_gate", int'(s_w_tready) + int'(s_wfc_tready), 0);
                img_snk++;
                img_beats++;
            end
            if (m_w_tvalid && m_w_tready) begin
                check("w_data", m_w_tdata, w_snk % 2);
                check("w_gate", int'(s_img_tready) + int'(s_wfc_tready), 0);
                w_snk++;
                w_beats++;
            end
            if (m_wfc_tvalid && m_wfc_tready) begin
                check("wfc_data", m_wfc_tdata, wfc_snk % 2);
                check("wfc_gate", int'(s_img_tready) + int'(s_w_tready), 0);
                wfc_snk++;
                wfc_beats++;
            end
        end
    end

    initial begin : accel
        job_t j;
        result_tvalid = 1'b0;
        result_tdata = '0;
        cnn_done = 1'b0;
        forever begin
            @(negedge clk);
            if (start_cnn === 1'b1 && jobs.size() > 0) begin
                j = jobs.pop_front();
                run_job(j);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (class_tvalid === 1'b1) begin
                class_seen++;
                if (scb.size() == 0) begin
                    check("class_unexpected", 1, 0);
                end else begin
                    e = scb.pop_front();
                    check("class_idx", class_idx, e.idx);
                    check("class_score", class_score, e.score);
                    check("class_w_total", w_beats, e.w);
                    check("class_wfc_total", wfc_beats, e.wfc);
                    check("class_img_total", img_beats, e.img);
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        scores_t s;
        int n;
        cfg_start = 0;
        cfg_num_images = 0;
        cfg_load_w = 0;
        #2 rstn = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // one image with weights, clean streams, known winner
        for (int i = 0; i < NC; i++) s[i] = DW'(-5);
        s[7] = 32'd100;
        add_image(s, 1, 1);
        start_batch(1, 1);
        check("a_busy", busy, 1);
        wait_done(20000, "a");
        end_checks("a");

        // weights and images under random backpressure
        vpct = 60; rpct = 50;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NC; i++) s[i] = $urandom();
            add_image(s, k * 2, k == 0);
        end
        start_batch(2, 1);
        wait_done(40000, "b");
        end_checks("b");

        // three images without weights; tie, all negative, small range
        vpct = 80; rpct = 80;
        for (int i = 0; i < NC; i++) s[i] = DW'(int'($urandom_range(0, 40)) - 20);
        s[2] = 32'd50; s[5] = 32'd50;
        add_image(s, 0, 0);
        for (int i = 0; i < NC; i++) s[i] = DW'(-(i + 1));
        add_image(s, 1, 0);
        for (int i = 0; i < NC; i++) s[i] = DW'(int'($urandom_range(0, 4)) - 2);
        add_image(s, 2, 0);
        start_batch(3, 0);
        repeat (40) @(negedge clk);
        cfg_start = 1'b1; cfg_num_images = 16'd1; cfg_load_w = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("c_busy_ignore", busy, 1);
        wait_done(20000, "c");
        end_checks("c");

        // timeout: no completion from the accelerator
        vpct = 100; rpct = 100;
        for (int i = 0; i < NC; i++) s[i] = $urandom();
        add_image(s, 3, 0);
        start_batch(1, 0);
        n = 0;
        while (start_cnn !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (start_cnn === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("to_run_cycles", n, TO);
        check("to_err", err, 1);
        check("to_start", start_cnn, 0);
        check("to_busy", busy, 0);
        check("to_gates", {s_img_tready, m_img_tvalid, s_w_tready}, 0);
        repeat (5) @(negedge clk);
        check("to_err_sticky", err, 1);
        for (int i = 0; i < NC; i++) s[i] = $urandom();
        add_image(s, 1, 0);
        start_batch(1, 0);
        check("to_err_clear", err, 0);
        check("to_restart_busy", busy, 1);
        wait_done(20000, "r");
        end_checks("r");

        // reset in the middle of the FC weight load
        vpct = 70; rpct = 70;
        start_batch(1, 1);
        n = 0;
        while (wfc_beats < mwfc + 500 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_fcw", wfc_beats >= mwfc + 500, 1);
        #3 rstn = 1'b0;
        #1 check_outputs_zero("rst_mid");
        repeat (2) @(negedge clk);
        w_beats = 0; wfc_beats = 0; img_beats = 0;
        mw = 0; mwfc = 0; mimg = 0;
        rstn = 1'b1;
        for (int i = 0; i < NC; i++) s[i] = $urandom();
        add_image(s, 2, 1);
        start_batch(1, 1);
        wait_done(20000, "x");
        end_checks("x");

        // empty batch: done pulse and nothing else
        start_batch(0, 1);
        check("z_done", done, 1);
        check("z_busy", busy, 0);
        @(negedge clk);
        check("z_done_drop", done, 0);
        repeat (5) @(negedge clk);
        end_checks("z");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
